// File: rtl/mips_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_core_pkg                                                        |
// | Shared types and constants for the MIPS-style front end.             |
// | Contents: BranchOutcome, fetch_qentry_t, PC_W, INSN_BYTES,           |
// |           DELAY_SLOT_OFFSET.                                         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mips_core_pkg;

   // Architectural fetch PC width used by the in-flight entry layout.
   localparam int PC_W = 26;

   // Sequential fetch step and the offset from a branch to its
   // fall-through (the delay slot at +4 is always fetched).
   localparam int INSN_BYTES        = 4;
   localparam int DELAY_SLOT_OFFSET = 8;

   typedef enum logic {
      BR_NOT_TAKEN = 1'b0,
      BR_TAKEN     = 1'b1
   } BranchOutcome;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      BranchOutcome    pred_tk;
      logic [PC_W-1:0] target;
   } fetch_qentry_t;

endpackage
`default_nettype wire

// File: rtl/pred_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pred_fifo                                                            |
// | Synchronous FIFO holding the prediction recorded for each fetch.     |
// | Ports: clk, rst (sync, active-high), push/push_data, pop, clear,     |
// |        head (oldest entry), count, full.                             |
// | Push while full and pop while empty are ignored.                     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pred_fifo
   import mips_core_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type ENTRY_T = fetch_qentry_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  ENTRY_T                   push_data,
   input  logic                     pop,
   input  logic                     clear,
   output ENTRY_T                   head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   ENTRY_T             mem [DEPTH];
   logic [PTR_W-1:0]   head_ptr;
   logic [PTR_W-1:0]   tail_ptr;
   logic [CNT_W-1:0]   cnt;
   logic               do_push;
   logic               do_pop;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & (cnt != '0);
   assign head    = mem[head_ptr];
   assign count   = cnt;

   // Storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push && !clear && !rst) begin
         mem[tail_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         cnt      <= '0;
      end else begin
         if (do_push) tail_ptr <= tail_ptr + 1'b1;
         if (do_pop)  head_ptr <= head_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pc_sequencer                                                   |
// | Fetch-stage next-PC generator. Owns the fetch PC, records each       |
// | issued fetch with its prediction, and checks decode resolutions      |
// | against the oldest record, redirecting and flushing on mispredict.   |
// | Ports: clk, rst (sync, active-high), i_stall, o_if_pc, o_if_valid,   |
// |        i_pred_valid/taken/target (BTB), i_dec_advance,               |
// |        i_res_valid/taken/target (decode), o_redirect, o_redirect_pc, |
// |        o_flush, o_q_full, o_underflow (sticky).                      |
// | ADDR_WIDTH must equal mips_core_pkg::PC_W (queue entry layout).      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fetch_pc_sequencer
   import mips_core_pkg::*;
#(
   parameter int                    ADDR_WIDTH = PC_W,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    QDEPTH     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_stall,
   output logic [ADDR_WIDTH-1:0] o_if_pc,
   output logic                  o_if_valid,
   input  logic                  i_pred_valid,
   input  logic                  i_pred_taken,
   input  logic [ADDR_WIDTH-1:0] i_pred_target,
   input  logic                  i_dec_advance,
   input  logic                  i_res_valid,
   input  logic                  i_res_taken,
   input  logic [ADDR_WIDTH-1:0] i_res_target,
   output logic                  o_redirect,
   output logic [ADDR_WIDTH-1:0] o_redirect_pc,
   output logic                  o_flush,
   output logic                  o_q_full,
   output logic                  o_underflow
);

   localparam int CNT_W = $clog2(QDEPTH) + 1;

   logic [ADDR_WIDTH-1:0] pc;
   logic                  underflow;
   logic                  pred_tk;
   BranchOutcome          res_outcome;
   fetch_qentry_t         push_entry;
   fetch_qentry_t         head_entry;
   logic [CNT_W-1:0]      count;
   logic                  q_full;
   logic                  q_empty;
   logic                  res_check;
   logic                  mispredict;
   logic [ADDR_WIDTH-1:0] corr_pc;
   logic                  fetch_fire;
   logic                  pop;

   assign pred_tk     = i_pred_valid & i_pred_taken;
   assign res_outcome = BranchOutcome'(i_res_taken);
   assign q_empty     = (count == '0);

   // A resolution against an empty queue is an error, never a redirect.
   assign res_check = i_res_valid & ~q_empty & ~rst;

   // Outcome disagreement, or both taken toward different targets.
   assign mispredict = res_check &
                       ((head_entry.pred_tk != res_outcome) ||
                        ((res_outcome == BR_TAKEN) &&
                         (head_entry.target != i_res_target)));

   assign corr_pc = (res_outcome == BR_TAKEN)
                    ? i_res_target
                    : head_entry.pc + ADDR_WIDTH'(DELAY_SLOT_OFFSET);

   // q_full comes from the registered count, so a pop in the same cycle
   // cannot open a slot for a push until the following cycle.
   assign fetch_fire = ~rst & ~i_stall & ~q_full & ~mispredict;
   assign pop        = i_dec_advance & ~q_empty & ~mispredict & ~rst;

   assign push_entry.pc      = pc;
   assign push_entry.pred_tk = BranchOutcome'(pred_tk);
   assign push_entry.target  = i_pred_target;

   pred_fifo #(
      .DEPTH   (QDEPTH),
      .ENTRY_T (fetch_qentry_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fetch_fire),
      .push_data (push_entry),
      .pop       (pop),
      .clear     (mispredict),
      .head      (head_entry),
      .count     (count),
      .full      (q_full)
   );

   // Redirect outranks every other PC update.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (mispredict) begin
         pc <= corr_pc;
      end else if (fetch_fire) begin
         pc <= pred_tk ? i_pred_target : pc + ADDR_WIDTH'(INSN_BYTES);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         underflow <= 1'b0;
      end else if ((i_dec_advance || i_res_valid) && q_empty) begin
         underflow <= 1'b1;
      end
   end

   assign o_if_pc       = pc;
   assign o_if_valid    = fetch_fire;
   assign o_redirect    = mispredict;
   assign o_flush       = mispredict;
   assign o_redirect_pc = corr_pc;
   assign o_q_full      = q_full;
   assign o_underflow   = underflow;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_pc_sequencer                                                |
// | Directed self-checking bench for fetch_pc_sequencer.                 |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_fetch_pc_sequencer;

   localparam int AW = 26;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_stall;
   logic [AW-1:0] o_if_pc;
   logic          o_if_valid;
   logic          i_pred_valid;
   logic          i_pred_taken;
   logic [AW-1:0] i_pred_target;
   logic          i_dec_advance;
   logic          i_res_valid;
   logic          i_res_taken;
   logic [AW-1:0] i_res_target;
   logic          o_redirect;
   logic [AW-1:0] o_redirect_pc;
   logic          o_flush;
   logic          o_q_full;
   logic          o_underflow;

   int checks = 0;
   int errors = 0;

   fetch_pc_sequencer #(
      .ADDR_WIDTH (AW),
      .RESET_PC   (26'h0),
      .QDEPTH     (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_stall       (i_stall),
      .o_if_pc       (o_if_pc),
      .o_if_valid    (o_if_valid),
      .i_pred_valid  (i_pred_valid),
      .i_pred_taken  (i_pred_taken),
      .i_pred_target (i_pred_target),
      .i_dec_advance (i_dec_advance),
      .i_res_valid   (i_res_valid),
      .i_res_taken   (i_res_taken),
      .i_res_target  (i_res_target),
      .o_redirect    (o_redirect),
      .o_redirect_pc (o_redirect_pc),
      .o_flush       (o_flush),
      .o_q_full      (o_q_full),
      .o_underflow   (o_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_stall = 0; i_pred_valid = 0; i_pred_taken = 0; i_pred_target = '0;
      i_dec_advance = 0; i_res_valid = 0; i_res_taken = 0; i_res_target = '0;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [31:0] cnt;

   initial begin
      rst = 1'b1;
      idle_inputs();
      tick(); tick();
      // Reset state (rst still high)
      chk("rst_pc", 32'(o_if_pc), 32'h0);
      chk("rst_valid", 32'(o_if_valid), 0);
      chk("rst_redirect", 32'(o_redirect), 0);
      chk("rst_full", 32'(o_q_full), 0);
      chk("rst_underflow", 32'(o_underflow), 0);

      // Free running sequential fetch: 0, 4, 8
      rst = 1'b0; settle();
      chk("seq_pc0", 32'(o_if_pc), 32'h0);
      chk("seq_valid0", 32'(o_if_valid), 1);
      tick();
      i_dec_advance = 1; settle();
      chk("seq_pc4", 32'(o_if_pc), 32'h4);
      chk("seq_valid4", 32'(o_if_valid), 1);
      tick(); settle();
      chk("seq_pc8", 32'(o_if_pc), 32'h8);
      chk("seq_noredir", 32'(o_redirect), 0);
      tick(); tick();                      // pc 0xC -> 0x10, count 1

      // Predicted taken at 0x10 -> 0x40
      chk("pc_0x10", 32'(o_if_pc), 32'h10);
      i_pred_valid = 1; i_pred_taken = 1; i_pred_target = 26'h40;
      tick();
      chk("pred_tk_pc", 32'(o_if_pc), 32'h40);
      cnt = 32'(dut.u_fifo.count);
      chk("pred_tk_cnt", cnt, 1);
      // Correctly predicted taken resolution
      i_pred_valid = 0; i_pred_taken = 0;
      i_res_valid = 1; i_res_taken = 1; i_res_target = 26'h40; settle();
      chk("good_tk_noredir", 32'(o_redirect), 0);
      tick();
      chk("good_tk_pc", 32'(o_if_pc), 32'h44);
      chk("good_tk_head", 32'(dut.u_fifo.head.pc), 32'h40);

      // Head 0x40 predicted NT, resolves taken to 0x20
      i_res_target = 26'h20; settle();
      chk("mp1_redir", 32'(o_redirect), 1);
      chk("mp1_flush", 32'(o_flush), 1);
      chk("mp1_rpc", 32'(o_redirect_pc), 32'h20);
      chk("mp1_valid", 32'(o_if_valid), 0);
      tick();
      i_res_valid = 0; i_dec_advance = 0; settle();
      chk("mp1_pc", 32'(o_if_pc), 32'h20);
      chk("mp1_cnt", 32'(dut.u_fifo.count), 0);
      chk("mp1_refetch", 32'(o_if_valid), 1);
      tick();                              // push 0x20 NT, pc 0x24

      // NT-predicted 0x20 resolves taken to 0x80
      i_res_valid = 1; i_res_taken = 1; i_res_target = 26'h80; i_dec_advance = 1; settle();
      chk("mp2_redir", 32'(o_redirect), 1);
      chk("mp2_rpc", 32'(o_redirect_pc), 32'h80);
      tick();
      i_res_valid = 0; i_dec_advance = 0; settle();
      chk("mp2_pc", 32'(o_if_pc), 32'h80);
      chk("mp2_cnt", 32'(dut.u_fifo.count), 0);
      tick();                              // push 0x80 NT, pc 0x84
      i_res_valid = 1; i_res_taken = 1; i_res_target = 26'h30; i_dec_advance = 1;
      tick();
      i_res_valid = 0; i_dec_advance = 0; settle();
      chk("mp3_pc", 32'(o_if_pc), 32'h30);

      // Predicted taken at 0x30 -> 0x40, resolves not taken -> 0x38
      i_pred_valid = 1; i_pred_taken = 1; i_pred_target = 26'h40;
      tick();
      i_pred_valid = 0; i_pred_taken = 0;
      i_res_valid = 1; i_res_taken = 0; i_res_target = 26'h0; i_dec_advance = 1; settle();
      chk("mp4_redir", 32'(o_redirect), 1);
      chk("mp4_rpc", 32'(o_redirect_pc), 32'h38);
      tick();
      i_res_valid = 0; i_dec_advance = 0; settle();
      chk("mp4_pc", 32'(o_if_pc), 32'h38);

      // Both taken, wrong target: 0x38 predicted -> 0x100, actual 0x104
      i_pred_valid = 1; i_pred_taken = 1; i_pred_target = 26'h100;
      tick();
      i_pred_valid = 0; i_pred_taken = 0;
      i_res_valid = 1; i_res_taken = 1; i_res_target = 26'h104; i_dec_advance = 1; settle();
      chk("mp5_redir", 32'(o_redirect), 1);
      chk("mp5_rpc", 32'(o_redirect_pc), 32'h104);
      tick();
      i_res_valid = 0; i_dec_advance = 0; settle();
      chk("mp5_pc", 32'(o_if_pc), 32'h104);

      // Fill the queue without decode advancing
      tick(); tick(); tick(); tick();
      chk("full_flag", 32'(o_q_full), 1);
      chk("full_valid", 32'(o_if_valid), 0);
      chk("full_pc", 32'(o_if_pc), 32'h114);
      tick();
      chk("full_frozen", 32'(o_if_pc), 32'h114);
      i_dec_advance = 1; settle();
      chk("full_pop_valid", 32'(o_if_valid), 0);
      tick();
      i_dec_advance = 0; settle();
      chk("after_pop_cnt", 32'(dut.u_fifo.count), 3);
      chk("after_pop_valid", 32'(o_if_valid), 1);
      tick();
      chk("resume_pc", 32'(o_if_pc), 32'h118);
      chk("resume_cnt", 32'(dut.u_fifo.count), 4);

      // Head 0x108 predicted NT resolves NT: no redirect, pop
      i_res_valid = 1; i_res_taken = 0; i_dec_advance = 1; settle();
      chk("good_nt_noredir", 32'(o_redirect), 0);
      tick();
      i_res_valid = 0;
      chk("good_nt_cnt", 32'(dut.u_fifo.count), 3);

      // Drain with fetch stalled, then pop on empty
      i_stall = 1;
      tick(); tick(); tick();
      chk("drained_cnt", 32'(dut.u_fifo.count), 0);
      chk("no_uf_yet", 32'(o_underflow), 0);
      settle();
      chk("uf_noredir", 32'(o_redirect), 0);
      tick();
      i_dec_advance = 0;
      chk("uf_set", 32'(o_underflow), 1);
      tick();
      chk("uf_sticky", 32'(o_underflow), 1);

      // Refill, then reset mid-stream
      i_stall = 0;
      tick(); tick();
      chk("refill_pc", 32'(o_if_pc), 32'h120);
      chk("refill_cnt", 32'(dut.u_fifo.count), 2);
      rst = 1;
      tick();
      chk("mid_rst_pc", 32'(o_if_pc), 32'h0);
      chk("mid_rst_cnt", 32'(dut.u_fifo.count), 0);
      chk("mid_rst_uf", 32'(o_underflow), 0);
      chk("mid_rst_valid", 32'(o_if_valid), 0);
      rst = 0; settle();
      chk("post_rst_valid", 32'(o_if_valid), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time bound so the bench can never hang.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
